// File: rtl/uart_transmitter.sv
// UART transmitter: one start bit, DATA_WIDTH data bits LSB-first, optional parity, one stop bit.
// Each bit is held for `prescale` clocks. The configuration is captured when a word is accepted.
module uart_transmitter #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  parity_type,
    input  logic                  parity_enable,
    input  logic [5:0]            prescale,
    input  logic                  data_valid,
    input  logic [DATA_WIDTH-1:0] parallel_data,
    output logic                  serial_data_out,
    output logic                  busy
);
    localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t                state;
    logic [5:0]            timer;
    logic [5:0]            bit_last;
    logic [IW-1:0]         bit_idx;
    logic [DATA_WIDTH-1:0] shreg;
    logic                  par_en;
    logic                  par_bit;
    logic                  bit_done;

    assign bit_done = (timer == bit_last);

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            timer           <= '0;
            bit_last        <= '0;
            bit_idx         <= '0;
            shreg           <= '0;
            par_en          <= 1'b0;
            par_bit         <= 1'b0;
            serial_data_out <= 1'b1;
            busy            <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    serial_data_out <= 1'b1;
                    busy            <= 1'b0;
                    timer           <= '0;
                    bit_idx         <= '0;
                    if (data_valid) begin
                        // Parity is resolved here so later input changes cannot reach the frame.
                        shreg           <= parallel_data;
                        par_en          <= parity_enable;
                        par_bit         <= (^parallel_data) ^ parity_type;
                        bit_last        <= (prescale == 6'd0) ? 6'd0 : prescale - 6'd1;
                        state           <= START;
                        serial_data_out <= 1'b0;
                        busy            <= 1'b1;
                    end
                end
                START: begin
                    if (bit_done) begin
                        timer           <= '0;
                        bit_idx         <= '0;
                        serial_data_out <= shreg[0];
                        shreg           <= shreg >> 1;
                        state           <= DATA;
                    end else begin
                        timer <= timer + 6'd1;
                    end
                end
                DATA: begin
                    if (bit_done) begin
                        timer <= '0;
                        if (bit_idx == LAST_IDX) begin
                            bit_idx <= '0;
                            if (par_en) begin
                                serial_data_out <= par_bit;
                                state           <= PARITY;
                            end else begin
                                serial_data_out <= 1'b1;
                                state           <= STOP;
                            end
                        end else begin
                            bit_idx         <= bit_idx + 1'b1;
                            serial_data_out <= shreg[0];
                            shreg           <= shreg >> 1;
                        end
                    end else begin
                        timer <= timer + 6'd1;
                    end
                end
                PARITY: begin
                    if (bit_done) begin
                        timer           <= '0;
                        serial_data_out <= 1'b1;
                        state           <= STOP;
                    end else begin
                        timer <= timer + 6'd1;
                    end
                end
                STOP: begin
                    if (bit_done) begin
                        timer           <= '0;
                        serial_data_out <= 1'b1;
                        busy            <= 1'b0;
                        state           <= IDLE;
                    end else begin
                        timer <= timer + 6'd1;
                    end
                end
                default: begin
                    state           <= IDLE;
                    timer           <= '0;
                    serial_data_out <= 1'b1;
                    busy            <= 1'b0;
                end
            endcase
        end
    end
endmodule
